icache_axi_refill: RTL
======================

# icache_axi_refill

Refill bridge between the instruction cache miss port and the AXI read channel. Accepts a one-line read request (`rd_req`/`rd_addr`) from the icache, issues one 8-beat INCR burst of 32-bit words on AXI AR/R, assembles the beats into a 256-bit line and returns it on `ret_valid`/`ret_data` for exactly one cycle. Sits directly downstream of the icache on its memory side and upstream of the AXI interconnect; one outstanding refill at a time.

## Interface
- `AXI_ID`, 4'd0, constant driven on `arid`.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `rd_req`  in  1  icache refill request, level; sampled only in IDLE.
- `rd_addr`  in  32  refill address; bits [4:0] ignored (line aligned).
- `ret_valid`  out  1  one-cycle pulse: `ret_data` holds the full line.
- `ret_data`  out  256  line; word i in bits [32i+31:32i].
- `refill_err`  out  1  one-cycle pulse coincident with `ret_valid` if any beat had `rresp`≠0 or `rlast` mismatched.
- `arid`  out  4  = `AXI_ID`.
- `araddr`  out  32  `{rd_addr[31:5],5'b0}` latched at accept.
- `arlen`  out  8  constant 8'd7.
- `arsize`  out  3  constant 3'b010.
- `arburst`  out  2  constant 2'b01 (INCR).
- `arvalid`  out  1  address valid.
- `arready`  in  1  address accepted.
- `rdata`  in  32  read beat data.
- `rresp`  in  2  beat response.
- `rlast`  in  1  last beat marker.
- `rvalid`  in  1  beat valid.
- `rready`  out  1  beat accept.

## Operation
- States: IDLE, ADDR, DATA, DONE. Reset → IDLE.
- IDLE: if `rd_req`=1, latch aligned address into `araddr`, clear beat counter and error flag, go ADDR. Otherwise stay.
- ADDR: `arvalid`=1, `araddr` stable. On `arvalid&&arready` go DATA. `arvalid` never drops before handshake.
- DATA: `rready`=1. Each `rvalid&&rready` writes `rdata` into word slot `cnt` of the line buffer, `cnt` (3 bits) increments. Error flag set if `rresp`≠2'b00, or `rlast`=1 with `cnt`<7, or `rlast`=0 with `cnt`=7. Beat with `cnt`=7 → DONE. Control follows the counter only; `rlast` affects only the error flag.
- DONE: `ret_valid`=1, `refill_err`=error flag, for exactly one cycle; then IDLE. `rd_req` in DONE is ignored (the icache drops it the cycle after `ret_valid`).
- `rd_req` outside IDLE never restarts or alters the active burst.
- Line buffer is `ret_data` directly; it holds its value after DONE until overwritten by beats of the next refill.
- `arid`, `arlen`, `arsize`, `arburst` are constants.

## Timing
- Reset values: `arvalid`=0, `araddr`=0, `rready`=0, `ret_valid`=0, `ret_data`=0, `refill_err`=0, state IDLE, `cnt`=0.
- Reset mid-burst: next cycle IDLE, `arvalid`/`rready`/`ret_valid` low; partial line discarded, no `ret_valid`.
- All outputs registered or decoded from state only; no combinational path from AXI inputs to `ret_valid`, `arvalid`, `rready`.
- `rd_req` high in cycle 0 → `arvalid` high in cycle 1.
- Minimum latency with `arready` and `rvalid` always high: AR handshake cycle 1, beats cycles 2–9, `ret_valid` cycle 10 (10 cycles `rd_req` → `ret_valid`).
- `rvalid` gaps stall DATA without loss; `arready` low holds ADDR indefinitely.
- After DONE, earliest next accept is the cycle after the `ret_valid` cycle.

## Test plan
- Basic refill: `rd_req`, `rd_addr`=32'h1C00_0044, `arready`/`rvalid` always 1, beats 32'hA0..A7 with `rlast` on 8th → `araddr`=32'h1C00_0040, `arlen`=7, `ret_valid` once at cycle 10, `ret_data`[31:0]=A0, [255:224]=A7, `refill_err`=0.
- Backpressure: `arready` low 3 cycles, `rvalid` low every other cycle → `arvalid`/`araddr` held stable until accept, line identical to basic case, `ret_valid` single pulse.
- Error: `rresp`=2'b10 on beat 3 → all 8 beats still consumed, `ret_valid` and `refill_err` both pulse in the same cycle; `rlast` on beat 5 → `refill_err`=1 too.
- Request churn: `rd_req` held continuously, `rd_addr` changed mid-burst to 32'h0000_1000 → active burst unaffected, returned line from original address; new request accepted only after DONE.
- Reset mid-DATA after 4 beats → next cycle IDLE, `rready`=0, no `ret_valid`; subsequent refill completes normally with fresh data.

Source files
------------

// File: rtl/icache_axi_refill.sv
// icache_axi_refill: bridge from the icache miss port to an AXI read channel.
// It takes one line request, issues a single 8-beat INCR burst of 32-bit words,
// collects the beats into a 256-bit line and presents it for one cycle.
// Only one refill is in flight at a time. rd_req is ignored while a burst is active.

module icache_axi_refill #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic         clk,
  input  logic         reset,
  // icache side
  input  logic         rd_req,
  input  logic [31:0]  rd_addr,
  output logic         ret_valid,
  output logic [255:0] ret_data,
  output logic         refill_err,
  // AXI read address channel
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  // AXI read data channel
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic        err_flag;
  logic        beat_err;
  logic [31:0] aligned_addr;

  // Burst shape never changes: one line is always eight 4-byte INCR beats.
  assign arid    = AXI_ID;
  assign arlen   = 8'd7;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  // Masking keeps the low offset bits out of the address; the line is always fetched whole.
  assign aligned_addr = rd_addr & 32'hFFFF_FFE0;

  // A beat is faulty on a non-OKAY response or when rlast disagrees with the
  // beat position. rlast is used only here. The beat counter alone ends the burst.
  assign beat_err = (rresp != 2'b00) ||
                    ( rlast && (cnt != 3'd7)) ||
                    (!rlast && (cnt == 3'd7));

  // Refill sequencer. Every output that the handshakes depend on is a flop
  // that is set when the state changes. This keeps AXI inputs off any combinational path to outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      err_flag   <= 1'b0;
      arvalid    <= 1'b0;
      araddr     <= 32'd0;
      rready     <= 1'b0;
      ret_valid  <= 1'b0;
      refill_err <= 1'b0;
      ret_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req) begin
            araddr   <= aligned_addr;
            cnt      <= 3'd0;
            err_flag <= 1'b0;
            arvalid  <= 1'b1;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (rvalid) begin
            ret_data[{cnt, 5'b00000} +: 32] <= rdata;
            cnt <= cnt + 3'd1;
            if (beat_err) begin
              err_flag <= 1'b1;
            end
            if (cnt == 3'd7) begin
              rready     <= 1'b0;
              ret_valid  <= 1'b1;
              refill_err <= err_flag | beat_err;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          ret_valid  <= 1'b0;
          refill_err <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
